mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: instruction fetch vs. load/store.
// One access is in flight at a time. An access is issued combinationally
// from IDLE and completes in the following BUSY cycle, where the memory
// response is forwarded to the owning requester as a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [DATA_W/8-1:0]   ls_strb,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_err,
  output logic                  mem_cen,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_strb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // 0 = fetch granted last, 1 = data granted last
  logic   any_req;
  logic   grant_d;

  assign any_req = if_req | ls_req;
  // Data wins when alone, or when both request and fetch was granted last.
  assign grant_d = ls_req & (~if_req | ~last_grant);

  // State and last-grant tracking; an issue happens on every IDLE cycle with a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= grant_d ? BUSY_D : BUSY_I;
            last_grant <= grant_d;
          end
        end
        BUSY_I:  state <= IDLE;
        BUSY_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory issue in IDLE and response routing in BUSY; everything is held at 0 during reset.
  always_comb begin
    mem_cen   = 1'b0;
    mem_wr    = 1'b0;
    mem_strb  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    ls_ack    = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_cen = 1'b1;
            if (grant_d) begin
              mem_wr    = ls_wr;
              mem_strb  = ls_strb;
              mem_addr  = ls_addr;
              mem_wdata = ls_wdata;
            end else begin
              mem_strb  = '1;
              mem_addr  = if_addr;
            end
          end
        end
        BUSY_I: begin
          if_ack   = 1'b1;
          if_rdata = mem_rdata;
          if_err   = mem_error;
        end
        BUSY_D: begin
          ls_ack   = 1'b1;
          ls_rdata = mem_rdata;
          ls_err   = mem_error;
        end
        default: ;
      endcase
    end
  end

endmodule
